link_status_mon: RTL and testbench
==================================

Name: link_status_mon

Overview:
Per-channel link monitor for the fibre interrupter path: synchronises a raw optical-link data signal and the SFP loss-of-signal pin, and runs a max-on-time watchdog on the data. Produces the stretched activity flag and the latched error flag that drive the front-panel LEDs. One instance sits on the TX path and one on the RX path. Its outputs feed the LED controller's d1/err inputs and the gated interrupter output.

Parameters:
ACT_HOLD, 3000000, activity stretch length in clocks (50 ms at 60 MHz)
MAX_ON, 6000, maximum legal continuous high time of the data signal in clocks (100 us)
LOS_FILT, 600, clocks LOS must stay continuously asserted before it is accepted (10 us)
ERR_HOLD, 30000000, minimum error display time in clocks after the cause clears (500 ms)

Ports:
i_clk  input  1  system clock, 60 MHz
i_res_n  input  1  reset; asynchronous, active-low
i_sig  input  1  raw data/interrupter signal, asynchronous
i_los  input  1  SFP loss-of-signal, asynchronous, active-high
o_sig  output  1  synchronised (optionally gated) data signal
o_act  output  1  activity indicator, to LED green
o_err  output  1  error indicator, to LED red flash enable
o_err_code  output  2  0 none, 1 on-time overrun, 2 LOS, 3 reserved

Behaviour:
- Clock and reset: single clock domain. All flops are reset asynchronously by i_res_n low. All outputs are 0 in reset, and the FSM is in IDLE.
- Synchronisers: i_sig and i_los each pass through a 2-FF synchroniser (s_sig, s_los). Latency from input to s_* is 2 clocks. o_sig is registered from s_sig, giving 3 clocks from i_sig to o_sig.
- Edge detect: a rising edge of s_sig is s_sig=1 with its previous-cycle value 0.
- Activity stretch:
  - A rising edge loads act_cnt with ACT_HOLD-1 and sets o_act=1 on the next clock.
  - act_cnt decrements while nonzero. o_act clears in the cycle after act_cnt reaches 0.
  - A new edge while counting reloads the counter (retrigger).
  - A stuck-high signal does not retrigger.
- On-time watchdog:
  - on_cnt counts clocks with s_sig=1, saturates at MAX_ON, and clears when s_sig=0.
  - ovr pulses for 1 clock when on_cnt transitions to MAX_ON.
  - ovr_act stays high while on_cnt==MAX_ON and s_sig=1.
- LOS filter:
  - los_cnt counts clocks with s_los=1 and clears to 0 on any s_los=0 cycle.
  - los_ok = (los_cnt==LOS_FILT), held at saturation.
  - Deassertion is immediate on s_los=0.
- Error FSM, with states IDLE, ERR, HOLD:
  - IDLE -> ERR when los_ok or ovr_act.
  - ERR: o_err=1. Stays in ERR while any cause is active. When all causes clear, load hold_cnt with ERR_HOLD-1 and go to HOLD.
  - HOLD: o_err=1 while hold_cnt decrements. If a cause re-asserts, go back to ERR (the hold restarts later). When hold_cnt==0, go to IDLE.
  - o_err and o_err_code are registered from the FSM state and sampled cause.
  - Code priority: LOS(2) over overrun(1). The code latches the highest-priority cause seen in the current ERR episode and keeps it through HOLD. It returns to 0 in IDLE.
- Simultaneous events: an edge and an overrun in the same cycle are both processed, so activity and error can both be 1.
- Reset mid-operation: all counters and the FSM return to reset state immediately; no hold is completed.
- Counters: width is $clog2(param+1). All arithmetic is unsigned and has no wrap, because every counter saturates or stops at 0.

Optional Feature:
Macro LINK_MON_GATE_EN.
- Defined: o_sig is forced 0 while ovr_act=1 or los_ok=1. On overrun, o_sig stays 0 until s_sig returns low (no re-enable mid-pulse). This is the coil-protection cut-off.
- Undefined: o_sig = registered s_sig unconditionally. Error reporting is unchanged.

Decomposition:
- Shared package link_mon_pkg holds:
  - error code constants ERR_NONE=2'd0, ERR_OVR=2'd1, ERR_LOS=2'd2;
  - FSM state encodings;
  - default timing constants tied to the 60 MHz clock.
- One sub-module, sync_2ff (1-bit, reset to 0), instantiated twice.

Test Plan:
Use sim overrides ACT_HOLD=10, MAX_ON=8, LOS_FILT=4, ERR_HOLD=20.
- Single 3-clk pulse on i_sig -> o_sig high 3 clocks starting 3 clocks after input; o_act high exactly 10 clocks; o_err stays 0.
- Pulses every 6 clocks -> o_act stays continuously 1; drops 10 clocks after the final edge is detected.
- i_sig held high 30 clocks -> o_err rises 1 clock after on_cnt hits 8; code=1; with GATE_EN, o_sig falls at the same point. After i_sig drops, o_err stays high 20 more clocks then clears and code=0.
- i_los high 3 clocks then low -> no error. i_los high 10 clocks -> o_err with code=2. An overrun arriving during this LOS episode keeps code=2.
- A cause re-asserts at hold_cnt=5 -> FSM returns to ERR and the full 20-clock hold restarts after the cause clears.
- i_res_n pulsed low during ERR with i_sig high -> all outputs 0 asynchronously. After release with i_sig still high, o_err re-asserts only after 8 fresh counted high clocks.

Source files
------------

// File: rtl/link_mon_pkg.sv
// Shared definitions for the link status monitor: error codes, FSM states and
// default timing constants for the 60 MHz system clock.
package link_mon_pkg;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVR  = 2'd1;
    localparam logic [1:0] ERR_LOS  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int unsigned DEF_ACT_HOLD = 32'd3_000_000;   // 50 ms
    localparam int unsigned DEF_MAX_ON   = 32'd6_000;       // 100 us
    localparam int unsigned DEF_LOS_FILT = 32'd600;         // 10 us
    localparam int unsigned DEF_ERR_HOLD = 32'd30_000_000;  // 500 ms

    // Error codes are numbered in priority order, so the larger code wins.
    function automatic logic [1:0] code_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/link_status_mon.sv
// Per-channel link monitor: synchronises data and SFP LOS, stretches activity and
// latches errors. Macro LINK_MON_GATE_EN cuts o_sig during overrun or accepted LOS.
module link_status_mon
    import link_mon_pkg::*;
#(
    parameter int unsigned ACT_HOLD = DEF_ACT_HOLD,
    parameter int unsigned MAX_ON   = DEF_MAX_ON,
    parameter int unsigned LOS_FILT = DEF_LOS_FILT,
    parameter int unsigned ERR_HOLD = DEF_ERR_HOLD
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_sig,
    input  logic       i_los,
    output logic       o_sig,
    output logic       o_act,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam int unsigned AW = $clog2(ACT_HOLD + 1);
    localparam int unsigned OW = $clog2(MAX_ON + 1);
    localparam int unsigned LW = $clog2(LOS_FILT + 1);
    localparam int unsigned HW = $clog2(ERR_HOLD + 1);

    logic          s_sig;
    logic          s_los;
    logic          sig_prev_q;
    logic          rise;
    logic          ovr_act;
    logic          los_ok;
    logic          cause;
    logic [1:0]    cause_code;

    logic          sig_q,     sig_d;
    logic          act_q,     act_d;
    logic [AW-1:0] act_cnt_q, act_cnt_d;
    logic [OW-1:0] on_cnt_q,  on_cnt_d;
    logic [LW-1:0] los_cnt_q, los_cnt_d;
    state_e        state_q,   state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          err_q,     err_d;
    logic [1:0]    code_q,    code_d;

    sync_2ff u_sync_sig (.clk_i(i_clk), .rst_ni(i_res_n), .d_i(i_sig), .q_o(s_sig));
    sync_2ff u_sync_los (.clk_i(i_clk), .rst_ni(i_res_n), .d_i(i_los), .q_o(s_los));

    assign rise       = s_sig & ~sig_prev_q;
    assign ovr_act    = s_sig && (on_cnt_q == OW'(MAX_ON));
    // LOS acceptance drops in the same cycle the synchronised pin goes low.
    assign los_ok     = s_los && (los_cnt_q == LW'(LOS_FILT));
    assign cause      = ovr_act | los_ok;
    assign cause_code = los_ok ? ERR_LOS : (ovr_act ? ERR_OVR : ERR_NONE);

    // Datapath: output gating, activity stretch, on-time and LOS counters.
    always_comb begin
        act_d     = act_q;
        act_cnt_d = act_cnt_q;
        on_cnt_d  = on_cnt_q;
        los_cnt_d = los_cnt_q;

`ifdef LINK_MON_GATE_EN
        sig_d = s_sig & ~(ovr_act | los_ok);
`else
        sig_d = s_sig;
`endif

        if (rise) begin
            act_cnt_d = AW'(ACT_HOLD - 1);
            act_d     = 1'b1;
        end else if (act_cnt_q != '0) begin
            act_cnt_d = act_cnt_q - AW'(1);
            act_d     = 1'b1;
        end else begin
            act_d     = 1'b0;
        end

        if (!s_sig) begin
            on_cnt_d = '0;
        end else if (on_cnt_q != OW'(MAX_ON)) begin
            on_cnt_d = on_cnt_q + OW'(1);
        end

        if (!s_los) begin
            los_cnt_d = '0;
        end else if (los_cnt_q != LW'(LOS_FILT)) begin
            los_cnt_d = los_cnt_q + LW'(1);
        end
    end

    // Error FSM; the code keeps the worst cause seen until the episode returns to IDLE.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = err_q;
        code_d     = code_q;

        case (state_q)
            ST_IDLE: begin
                err_d  = 1'b0;
                code_d = ERR_NONE;
                if (cause) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    code_d  = cause_code;
                end
            end
            ST_ERR: begin
                err_d  = 1'b1;
                code_d = code_max(code_q, cause_code);
                if (!cause) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HW'(ERR_HOLD - 1);
                end
            end
            ST_HOLD: begin
                err_d = 1'b1;
                if (cause) begin
                    state_d = ST_ERR;
                    code_d  = code_max(code_q, cause_code);
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
                code_d  = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sig_prev_q <= 1'b0;
            sig_q      <= 1'b0;
            act_q      <= 1'b0;
            act_cnt_q  <= '0;
            on_cnt_q   <= '0;
            los_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            sig_prev_q <= s_sig;
            sig_q      <= sig_d;
            act_q      <= act_d;
            act_cnt_q  <= act_cnt_d;
            on_cnt_q   <= on_cnt_d;
            los_cnt_q  <= los_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign o_sig      = sig_q;
    assign o_act      = act_q;
    assign o_err      = err_q;
    assign o_err_code = code_q;

endmodule

// File: tb/tb_link_status_mon.sv
// Directed bench for link_status_mon with short timing overrides; loop index k is
// the clock edge counted from the start of each scenario's stimulus.
module tb_link_status_mon;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sig;
    logic       los;
    logic       o_sig;
    logic       o_act;
    logic       o_err;
    logic [1:0] o_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    link_status_mon #(
        .ACT_HOLD(10),
        .MAX_ON  (8),
        .LOS_FILT(4),
        .ERR_HOLD(20)
    ) dut (
        .i_clk     (clk),
        .i_res_n   (rst_n),
        .i_sig     (sig),
        .i_los     (los),
        .o_sig     (o_sig),
        .o_act     (o_act),
        .o_err     (o_err),
        .o_err_code(o_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sig   = 1'b0;
        los   = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0;
        sig   = 1'b1;
        los   = 1'b1;
        #1;
        got = {o_sig, o_act, o_err, o_code};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", got, 5'b0);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL reset_held k=%0d got=%b exp=%b", k, got, 5'b0);
            end
        end
        sig = 1'b0;
        los = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got, 5'b0);
            end
        end
    endtask

    task automatic test_single_pulse();
        logic [4:0] got, exp;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            sig = (k <= 3);
            tick();
            exp = {1'(k >= 3 && k <= 5), 1'(k >= 3 && k <= 12), 1'b0, 2'd0};
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_pulse k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_pulse_train();
        logic [4:0] got, exp;
        apply_reset();
        for (int k = 1; k <= 33; k++) begin
            sig = (k <= 21) && (((k - 1) % 6) < 3);
            tick();
            exp = {1'((k >= 3) && (k <= 23) && (((k - 3) % 6) < 3)),
                   1'(k >= 3 && k <= 30), 1'b0, 2'd0};
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pulse_train k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_overrun();
        logic [4:0] got, exp;
        logic       es, ee;
        apply_reset();
        for (int k = 1; k <= 56; k++) begin
            sig = (k <= 30);
            tick();
`ifdef LINK_MON_GATE_EN
            es = (k >= 3 && k <= 10);
`else
            es = (k >= 3 && k <= 32);
`endif
            ee  = (k >= 11 && k <= 52);
            exp = {es, 1'(k >= 3 && k <= 12), ee, ee ? 2'd1 : 2'd0};
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL overrun k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_los();
        logic [4:0] got, exp;
        logic       es, ee;
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            los = (k <= 3);
            tick();
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL los_short k=%0d got=%b exp=%b", k, got, 5'b0);
            end
        end
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            los = (k <= 10);
            sig = (k <= 12);
            tick();
`ifdef LINK_MON_GATE_EN
            es = (k >= 3 && k <= 6);
`else
            es = (k >= 3 && k <= 14);
`endif
            ee  = (k >= 7 && k <= 34);
            exp = {es, 1'(k >= 3 && k <= 12), ee, ee ? 2'd2 : 2'd0};
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL los_with_ovr k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_reassert();
        logic [4:0] got, exp;
        logic       es, ee;
        apply_reset();
        for (int k = 1; k <= 56; k++) begin
            sig = (k <= 12) || (k >= 20 && k <= 30);
            tick();
`ifdef LINK_MON_GATE_EN
            es = (k >= 3 && k <= 10) || (k >= 22 && k <= 29);
`else
            es = (k >= 3 && k <= 14) || (k >= 22 && k <= 32);
`endif
            ee  = (k >= 11 && k <= 52);
            exp = {es, 1'((k >= 3 && k <= 12) || (k >= 22 && k <= 31)), ee, ee ? 2'd1 : 2'd0};
            got = {o_sig, o_act, o_err, o_code};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reassert k=%0d got=%b exp=%b", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] got;
        logic [2:0] got_e, exp_e;
        apply_reset();
        for (int k = 1; k <= 14; k++) begin
            sig = 1'b1;
            tick();
        end
        checks++;
        if (o_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_err got=%b exp=%b", o_err, 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {o_sig, o_act, o_err, o_code};
        checks++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL mid_async_clear got=%b exp=%b", got, 5'b0);
        end
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_e = {1'(k >= 11), (k >= 11) ? 2'd1 : 2'd0};
            got_e = {o_err, o_code};
            checks++;
            if (got_e !== exp_e) begin
                errors++;
                $display("FAIL mid_recount k=%0d got=%b exp=%b", k, got_e, exp_e);
            end
        end
        sig = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_pulse_train();
        test_overrun();
        test_los();
        test_reassert();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
